// File: rtl/dma_ocram_arb_pkg.sv
// Shared constants and types for the DMA on-chip RAM arbiter slice.
package dma_ocram_arb_pkg;

    localparam int unsigned ADDR_W_DFLT = 10;
    localparam int unsigned DATA_W_DFLT = 32;
    localparam int unsigned STATS_W     = 32;

    typedef enum logic {
        M_CPU = 1'b0,
        M_DMA = 1'b1
    } master_e;

endpackage

// File: rtl/dma_ocram_arbiter_if.sv
// Bus bundle between the CPU/DMA Avalon-MM masters, the arbiter and the RAM slave port.
interface dma_ocram_arbiter_if
    import dma_ocram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byteenable;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byteenable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    modport slave (
        input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        input  ram_readdata
    );

    modport master (
        output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken,
        output ram_readdata
    );

endinterface

// File: rtl/dma_ocram_rr_arb2.sv
// Two-way round-robin grant logic; last_grant resets to M_DMA so M_CPU wins the first tie.
module dma_ocram_rr_arb2
    import dma_ocram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    master_e last_grant_q;
    master_e last_grant_d;

    always_comb begin
        grant_o      = '0;
        last_grant_d = last_grant_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_grant_q == M_DMA) ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
        if (grant_o[1]) begin
            last_grant_d = M_DMA;
        end else if (grant_o[0]) begin
            last_grant_d = M_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= M_DMA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dma_ocram_arbiter.sv
// Round-robin share of the single-port DMA on-chip RAM between CPU (m0) and DMA (m1).
// Define DMA_OCRAM_ARB_STATS_EN to add grant/conflict statistics counters and ports.
module dma_ocram_arbiter
    import dma_ocram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    dma_ocram_arbiter_if.slave bus
`ifdef DMA_OCRAM_ARB_STATS_EN
    ,
    input  logic               stats_clear,
    output logic [STATS_W-1:0] stats_grant0,
    output logic [STATS_W-1:0] stats_grant1,
    output logic [STATS_W-1:0] stats_conflict
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0] req;
    logic [1:0] grant;

    assign req[0] = bus.m0_read | bus.m0_write;
    assign req[1] = bus.m1_read | bus.m1_write;

    dma_ocram_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req),
        .grant_o (grant)
    );

    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_write;
    logic              sel_read;

    always_comb begin
        sel_address    = bus.m0_address;
        sel_byteenable = bus.m0_byteenable;
        sel_writedata  = bus.m0_writedata;
        sel_write      = bus.m0_write;
        sel_read       = bus.m0_read;
        if (grant[M_DMA]) begin
            sel_address    = bus.m1_address;
            sel_byteenable = bus.m1_byteenable;
            sel_writedata  = bus.m1_writedata;
            sel_write      = bus.m1_write;
            sel_read       = bus.m1_read;
        end
    end

    assign bus.m0_waitrequest = req[0] & ~grant[0];
    assign bus.m1_waitrequest = req[1] & ~grant[1];

    assign bus.ram_chipselect = |grant;
    assign bus.ram_write      = (|grant) & sel_write;
    assign bus.ram_address    = sel_address;
    assign bus.ram_byteenable = sel_byteenable;
    assign bus.ram_writedata  = sel_writedata;
    assign bus.ram_clken      = 1'b1;

    logic    rd_vld_q;
    logic    rd_vld_d;
    master_e rd_owner_q;
    master_e rd_owner_d;

    // A read that also asserts write is performed as a write, so no data return is scheduled.
    always_comb begin
        rd_vld_d   = (|grant) & sel_read & ~sel_write;
        rd_owner_d = rd_owner_q;
        if (rd_vld_d) begin
            rd_owner_d = grant[M_DMA] ? M_DMA : M_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            rd_owner_q <= M_CPU;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.m0_readdatavalid = rd_vld_q & (rd_owner_q == M_CPU);
    assign bus.m1_readdatavalid = rd_vld_q & (rd_owner_q == M_DMA);
    assign bus.m0_readdata      = bus.ram_readdata;
    assign bus.m1_readdata      = bus.ram_readdata;

    a_m0_no_rw: assert property (@(posedge clk) disable iff (reset) !(bus.m0_read && bus.m0_write))
        else $error("m0 asserted read and write together");
    a_m1_no_rw: assert property (@(posedge clk) disable iff (reset) !(bus.m1_read && bus.m1_write))
        else $error("m1 asserted read and write together");

`ifdef DMA_OCRAM_ARB_STATS_EN
    logic [STATS_W-1:0] stats_grant0_q;
    logic [STATS_W-1:0] stats_grant0_d;
    logic [STATS_W-1:0] stats_grant1_q;
    logic [STATS_W-1:0] stats_grant1_d;
    logic [STATS_W-1:0] stats_conflict_q;
    logic [STATS_W-1:0] stats_conflict_d;

    always_comb begin
        stats_grant0_d   = stats_grant0_q;
        stats_grant1_d   = stats_grant1_q;
        stats_conflict_d = stats_conflict_q;
        if (stats_clear) begin
            stats_grant0_d   = '0;
            stats_grant1_d   = '0;
            stats_conflict_d = '0;
        end else begin
            if (grant[0] && (stats_grant0_q != '1)) begin
                stats_grant0_d = stats_grant0_q + STATS_W'(1);
            end
            if (grant[1] && (stats_grant1_q != '1)) begin
                stats_grant1_d = stats_grant1_q + STATS_W'(1);
            end
            if ((&req) && (stats_conflict_q != '1)) begin
                stats_conflict_d = stats_conflict_q + STATS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stats_grant0_q   <= '0;
            stats_grant1_q   <= '0;
            stats_conflict_q <= '0;
        end else begin
            stats_grant0_q   <= stats_grant0_d;
            stats_grant1_q   <= stats_grant1_d;
            stats_conflict_q <= stats_conflict_d;
        end
    end

    assign stats_grant0   = stats_grant0_q;
    assign stats_grant1   = stats_grant1_q;
    assign stats_conflict = stats_conflict_q;
`endif

endmodule
